ksa: RTL
========

Name: ksa

Overview:
- Implements the ARC4 key-scheduling pass over the 256-byte S memory after the init block has filled it with S[i]=i.
- Reads S[i] and S[j], computes j = j + S[i] + key[i mod KEY_BYTES], then swaps the two entries.
- Sits between init and prga in the ARC4 top level and shares the single-port S memory through the top-level mux.
- Uses the same en/rdy start handshake as init.

Parameters:
KEY_BYTES, 3, number of key bytes; key width is 8*KEY_BYTES.

Ports:
clk  input  1  system clock
rst_n  input  1  active-low reset
en  input  1  start request; sampled only while rdy=1
rdy  output  1  high when idle and able to accept en
key  input  8*KEY_BYTES  cipher key; byte 0 is the most significant byte (key[8*KEY_BYTES-1 -: 8])
addr  output  8  S memory address
rddata  input  8  S memory read data, valid the cycle after addr is presented with wren=0
wrdata  output  8  S memory write data
wren  output  1  S memory write enable

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, i=0, j=0, key-byte index k=0, rdy=1, addr=0, wrdata=0, wren=0.
- Reset mid-operation aborts immediately with no further writes. The last memory write may have been partial; the top level re-runs init.
- Handshake:
  - A rising edge with en=1 and rdy=1 accepts the request and latches key internally.
  - rdy drops to 0 on that edge and stays 0 until the pass completes.
  - en while rdy=0 is ignored. Key changes after acceptance are ignored.
- State machine, one state per cycle, all outputs registered:
  - IDLE: rdy=1, wren=0. On accept, go to RD_I.
  - RD_I: addr=i, wren=0.
  - WT_I: rddata = S[i]. Latch si. Compute j <= j + si + keybyte[k], all mod 256 (8-bit wrap).
  - RD_J: addr=j (updated value), wren=0.
  - WT_J: rddata = S[j]. Latch sj.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1.
    - If i==255: go to IDLE, rdy=1 from the next cycle.
    - Else: i <= i+1, k <= (k==KEY_BYTES-1) ? 0 : k+1, go to RD_I.
- Latency: exactly 6 cycles per i, 1536 cycles from the accept edge to the edge on which rdy returns to 1.
- i==j: both writes store the same value, so S is unchanged. This is legal and not special-cased.
- j and k are reset to 0 on every accept, not only by rst_n. A second run after completion starts fresh.
- wren is 0 in every state except WR_I and WR_J. addr holds its last value in IDLE. wrdata changes only in write states.

Test Plan:
1. Release rst_n with memory preloaded S[i]=i and key=24'h00033C; pulse en -> rdy=1 before accept, 0 the cycle after. First writes: i=0 gives j=0, write addr0=0 twice. i=1 gives j=4: WR_I addr=1 wrdata=4, WR_J addr=4 wrdata=1.
2. Same run to completion -> rdy returns to 1 exactly 1536 cycles after accept. Final 256 bytes match a software ARC4 KSA model for key 00033C.
3. Assert en continuously and toggle key mid-run -> no restart, no extra accept, result identical to scenario 2.
4. key=24'h000000 with identity S -> i=0 gives j=0 (self-swap), i=1 gives j=1 (self-swap), i=2 gives j=3: writes addr2=3, addr3=2. Checks the i==j path and 8-bit wrap over the full run versus the model.
5. Assert rst_n=0 at cycle 700 of a run -> rdy=1, wren=0, addr=0 asynchronously, with no memory write afterwards. Re-init and re-run gives the scenario 2 result.
6. Back-to-back runs: accept a second en on the first cycle rdy=1 -> second pass starts with j=0, k=0; addr sequence restarts at 0.

Source files
------------

// File: rtl/ksa.sv
// ARC4 key-scheduling pass over a 256-byte single-port S memory.
// Six registered states per index: read S[i], read S[j], write both swapped values.
module ksa #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdI,
    StWtI,
    StRdJ,
    StWtJ,
    StWrI,
    StWrJ
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [KW-1:0]          k_q, k_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             wrdata_q, wrdata_d;
  logic                   wren_q, wren_d;
  logic                   rdy_q, rdy_d;
  logic [7:0]             key_byte;

  // Byte 0 of the key sits in the most significant position.
  always_comb begin
    key_byte = 8'd0;
    for (int b = 0; b < int'(KEY_BYTES); b++) begin
      if (k_q == KW'(b)) key_byte = key_q[8*(int'(KEY_BYTES)-1-b) +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    key_d    = key_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    rdy_d    = rdy_q;

    case (state_q)
      StIdle: begin
        if (en && rdy_q) begin
          key_d   = key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          addr_d  = 8'd0;
          rdy_d   = 1'b0;
          state_d = StRdI;
        end
      end
      StRdI: state_d = StWtI;
      StWtI: begin
        si_d    = rddata;
        j_d     = j_q + rddata + key_byte;
        addr_d  = j_q + rddata + key_byte;
        state_d = StRdJ;
      end
      StRdJ: state_d = StWtJ;
      StWtJ: begin
        sj_d     = rddata;
        addr_d   = i_q;
        wrdata_d = rddata;
        wren_d   = 1'b1;
        state_d  = StWrI;
      end
      StWrI: begin
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
        state_d  = StWrJ;
      end
      StWrJ: begin
        if (i_q == 8'd255) begin
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
          addr_d  = i_q + 8'd1;
          state_d = StRdI;
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      k_q      <= '0;
      si_q     <= 8'd0;
      sj_q     <= 8'd0;
      key_q    <= '0;
      addr_q   <= 8'd0;
      wrdata_q <= 8'd0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
    end
  end

  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;
  assign rdy    = rdy_q;

endmodule
